// File: rtl/byte_pkg.sv
// Shared types for the byte-wide memory port family (arbiter, demux, wrappers).
// Holds the default field widths of a memory request, the port-index type
// and the small {valid, port} tag used for lock and response state.
package byte_pkg;

  localparam int DEF_PORTS     = 4;
  localparam int DEF_DATA_BYTE = 4;
  localparam int DEF_ADDR_SIZE = 32;
  localparam int IDX_W         = 3;   // enough for up to 8 initiators

  typedef logic [DEF_DATA_BYTE-1:0]   mask_t;
  typedef logic [DEF_ADDR_SIZE-1:0]   addr_t;
  typedef logic [DEF_DATA_BYTE*8-1:0] data_t;
  typedef logic [IDX_W-1:0]           idx_t;

  // Valid flag plus owning port: used for the grant lock and the read response.
  typedef struct packed {
    logic vld;
    idx_t port;
  } slot_t;

endpackage

// File: rtl/byte_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req  : request vector
//   ptr  : last served index; search starts at ptr+1 (mod N)
//   gnt  : one-hot grant, idx : granted index, any : some request present
module rr_pick
  import byte_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  idx_t         ptr,
  output logic [N-1:0] gnt,
  output idx_t         idx,
  output logic         any
);

  int best;
  int d;

  // Rank every requester by its distance past ptr; the closest one wins.
  always_comb begin
    best = N;
    d    = 0;
    idx  = ptr;
    gnt  = '0;
    for (int j = 0; j < N; j++) begin
      d = (j - int'(ptr) - 1 + 2 * N) % N;
      if (req[j] && d < best) begin
        best = d;
        idx  = idx_t'(j);
      end
    end
    any = (best < N);
    for (int j = 0; j < N; j++) gnt[j] = any && (int'(idx) == j);
  end

endmodule

// File: rtl/byte_arbiter.sv
// byte_arbiter: round-robin arbiter of PORTS initiators onto one memory port.
//   use*_i / use*_o : per-initiator request, stall and read-data return
//   mem*_o / mem*_i : single memory port, driven combinationally from grant
// A held (memHold_i) grant is locked to its port until accepted. Read data
// returns one cycle after acceptance, straight from memReadData_i.
module byte_arbiter
  import byte_pkg::*;
#(
  parameter int PORTS     = DEF_PORTS,
  parameter int DATA_BYTE = DEF_DATA_BYTE,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [PORTS-1:0]                    useEnable_i,
  input  logic [PORTS-1:0]                    useIsWrite_i,
  input  logic [PORTS-1:0][DATA_BYTE-1:0]     useWriteMask_i,
  input  logic [PORTS-1:0][ADDR_SIZE-1:0]     useAddr_i,
  input  logic [PORTS-1:0][DATA_BYTE*8-1:0]   useWriteData_i,
  output logic [PORTS-1:0][DATA_BYTE*8-1:0]   useReadData_o,
  output logic [PORTS-1:0]                    useHold_o,
  output logic                                memEnable_o,
  output logic                                memIsWrite_o,
  output logic [DATA_BYTE-1:0]                memWriteMask_o,
  output logic [ADDR_SIZE-1:0]                memAddr_o,
  output logic [DATA_BYTE*8-1:0]              memWriteData_o,
  input  logic [DATA_BYTE*8-1:0]              memReadData_i,
  input  logic                                memHold_i
);

  idx_t  ptr;
  slot_t lock;
  slot_t resp;

  logic [PORTS-1:0] rr_gnt;
  idx_t             rr_idx;
  logic             rr_any;

  rr_pick #(.N(PORTS)) u_pick (
    .req (useEnable_i),
    .ptr (ptr),
    .gnt (rr_gnt),
    .idx (rr_idx),
    .any (rr_any)
  );

  logic             lock_live;
  logic [PORTS-1:0] lock_oh;
  logic [PORTS-1:0] gnt;
  logic             gnt_vld;
  idx_t             gnt_idx;
  logic             accept;

  // The lock only counts while its port still requests; a dropped enable
  // falls back to normal round-robin.
  always_comb begin
    lock_oh = '0;
    for (int i = 0; i < PORTS; i++)
      lock_oh[i] = lock.vld && (int'(lock.port) == i) && useEnable_i[i];
    lock_live = |lock_oh;
    gnt       = lock_live ? lock_oh   : rr_gnt;
    gnt_idx   = lock_live ? lock.port : rr_idx;
    gnt_vld   = lock_live | rr_any;
  end

  assign accept = gnt_vld & ~memHold_i;

  always_comb begin
    memEnable_o    = gnt_vld;
    memIsWrite_o   = 1'b0;
    memWriteMask_o = '0;
    memAddr_o      = '0;
    memWriteData_o = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (gnt[i]) begin
        memIsWrite_o   = useIsWrite_i[i];
        memWriteMask_o = useWriteMask_i[i];
        memAddr_o      = useAddr_i[i];
        memWriteData_o = useWriteData_i[i];
      end
    end
  end

  for (genvar g = 0; g < PORTS; g++) begin : g_port
    assign useHold_o[g]     = useEnable_i[g] & (~gnt[g] | memHold_i);
    assign useReadData_o[g] = (resp.vld && int'(resp.port) == g) ? memReadData_i : '0;
  end

  // ptr resets to PORTS-1 so the first search starts at port 0.
  // resp is valid only in the cycle right after an accepted read.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ptr  <= idx_t'(PORTS - 1);
      lock <= '0;
      resp <= '0;
    end else begin
      lock.vld  <= gnt_vld & memHold_i;
      lock.port <= gnt_idx;
      if (accept) ptr <= gnt_idx;
      resp.vld  <= accept & ~memIsWrite_o;
      resp.port <= gnt_idx;
    end
  end

endmodule

// File: tb/tb_byte_arbiter.sv
module tb_byte_arbiter;
  import byte_pkg::*;

  localparam int P = 4;

  logic                clk_i = 1'b0;
  logic                rst_i = 1'b0;
  logic [P-1:0]        en, wr;
  logic [P-1:0][3:0]   mask;
  logic [P-1:0][31:0]  addr, wdata, rdata_o;
  logic [P-1:0]        hold;
  logic                m_en, m_wr, m_hold;
  logic [3:0]          m_mask;
  logic [31:0]         m_addr, m_wdata, m_rdata;

  typedef struct {
    int          port;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } txn_t;

  txn_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #5 clk_i = ~clk_i;

  byte_arbiter #(.PORTS(P), .DATA_BYTE(4), .ADDR_SIZE(32)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .useEnable_i    (en),
    .useIsWrite_i   (wr),
    .useWriteMask_i (mask),
    .useAddr_i      (addr),
    .useWriteData_i (wdata),
    .useReadData_o  (rdata_o),
    .useHold_o      (hold),
    .memEnable_o    (m_en),
    .memIsWrite_o   (m_wr),
    .memWriteMask_o (m_mask),
    .memAddr_o      (m_addr),
    .memWriteData_o (m_wdata),
    .memReadData_i  (m_rdata),
    .memHold_i      (m_hold)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic req(input int p, input logic w, input logic [31:0] a,
                     input logic [3:0] m, input logic [31:0] d);
    en[p] = 1'b1; wr[p] = w; addr[p] = a; mask[p] = m; wdata[p] = d;
  endtask

  // Expect the port's currently driven request to be the next one accepted.
  task automatic want(input int p);
    txn_t t;
    t.port = p; t.wr = wr[p]; t.addr = addr[p]; t.mask = mask[p]; t.data = wdata[p];
    exp_q.push_back(t);
  endtask

  // Fresh read data every cycle so each response is distinguishable.
  initial forever begin
    @(posedge clk_i);
    #1;
    cyc++;
    m_rdata = 32'hC0DE_0000 + 32'(cyc);
  end

  // Monitor: pops the scoreboard on every acceptance, checks the read
  // return one cycle later.
  initial begin : mon
    bit   pend;
    int   pport;
    int   act;
    txn_t t;
    pend = 1'b0;
    pport = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          for (int i = 0; i < P; i++)
            chk($sformatf("rdata_p%0d", i), 64'(rdata_o[i]), (i == pport) ? 64'(m_rdata) : 64'd0);
          pend = 1'b0;
        end
        if (m_en && !m_hold) begin
          act = -1;
          for (int i = P - 1; i >= 0; i--) if (en[i] && !hold[i]) act = i;
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_accept actual_port=%0d addr=%0h expected=none", act, m_addr);
          end else begin
            t = exp_q.pop_front();
            chk("acc_port", 64'(act), 64'(t.port));
            chk("acc_wr",   64'(m_wr), 64'(t.wr));
            chk("acc_addr", 64'(m_addr), 64'(t.addr));
            chk("acc_mask", 64'(m_mask), 64'(t.mask));
            chk("acc_data", 64'(m_wdata), 64'(t.data));
            if (!t.wr) begin pend = 1'b1; pport = t.port; end
          end
        end
      end
    end
  end

  initial begin
    en = '0; wr = '0; mask = '0; addr = '0; wdata = '0; m_hold = 1'b0; m_rdata = '0;
    #12;
    // In reset with nothing requesting: everything idle.
    chk("rst_mem_en", 64'(m_en), 64'd0);
    chk("rst_addr",   64'(m_addr), 64'd0);
    chk("rst_hold",   64'(hold), 64'd0);
    chk("rst_rdata",  64'(|rdata_o), 64'd0);

    // All four ports read; port 0 goes first after reset.
    for (int p = 0; p < P; p++) req(p, 1'b0, 32'h100 + 32'(4 * p), 4'h0, 32'h0);
    #1;
    chk("rst_first_gnt", 64'(m_addr), 64'h100);
    want(0); want(1); want(2); want(3); want(0);
    step();
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("t1_hold", 64'(hold), 64'b1110);
    repeat (4) step();
    step();
    en = '0;

    // Port 2 write held 3 cycles; others join and must stay held.
    req(2, 1'b1, 32'h10, 4'b0011, 32'hDEADBEEF);
    m_hold = 1'b1;
    @(negedge clk_i);
    chk("t2_addr0", 64'(m_addr), 64'h10);
    chk("t2_hold0", 64'(hold), 64'b0100);
    step();
    req(0, 1'b0, 32'h100, 4'h0, 32'h0);
    req(1, 1'b0, 32'h104, 4'h0, 32'h0);
    req(3, 1'b0, 32'h10C, 4'h0, 32'h0);
    for (int k = 1; k < 3; k++) begin
      @(negedge clk_i);
      chk($sformatf("t2_lock_addr%0d", k), 64'(m_addr), 64'h10);
      chk($sformatf("t2_lock_hold%0d", k), 64'(hold), 64'b1111);
      step();
    end
    m_hold = 1'b0;
    want(2);
    @(negedge clk_i);
    chk("t2_acc_hold", 64'(hold), 64'b1011);
    step();
    en[2] = 1'b0; want(3);   // ptr now 2: port 3 next
    step();
    en[3] = 1'b0; want(0);
    step();
    en[0] = 1'b0; want(1);
    step();
    en = '0;

    // Port 1 alone: five back-to-back reads.
    for (int k = 0; k < 5; k++) begin
      req(1, 1'b0, 32'h200 + 32'(4 * k), 4'h0, 32'h0);
      want(1);
      @(negedge clk_i);
      chk($sformatf("t3_hold%0d", k), 64'(hold[1]), 64'd0);
      chk($sformatf("t3_men%0d", k),  64'(m_en), 64'd1);
      step();
    end
    en = '0;

    // Port 3 read, then port 0 write in the next cycle.
    req(3, 1'b0, 32'h30C, 4'h0, 32'h0);
    want(3);
    step();
    en[3] = 1'b0;
    req(0, 1'b1, 32'h300, 4'b1111, 32'h12345678);
    want(0);
    @(negedge clk_i);
    chk("t4_rd3", 64'(rdata_o[3]), 64'(m_rdata));
    chk("t4_rd0", 64'(rdata_o[0]), 64'd0);
    step();
    en = '0;
    // Port 2 read accepted now; the write left no response behind.
    req(2, 1'b0, 32'h400, 4'h0, 32'h0);
    want(2);
    @(negedge clk_i);
    chk("t4_wr_no_resp", 64'(|rdata_o), 64'd0);
    step();

    // Port 1 locked under hold, then reset hits.
    en[2] = 1'b0;
    req(1, 1'b0, 32'h404, 4'h0, 32'h0);
    m_hold = 1'b1;
    @(negedge clk_i);
    chk("t5_gnt1", 64'(m_addr), 64'h404);
    step();
    req(0, 1'b0, 32'h408, 4'h0, 32'h0);
    #1;
    chk("t5_lock", 64'(m_addr), 64'h404);
    #1;
    rst_i = 1'b0;
    #1;
    chk("t5_rst_gnt",   64'(m_addr), 64'h408);
    chk("t5_rst_hold1", 64'(hold[1]), 64'd1);
    step();
    rst_i  = 1'b1;
    m_hold = 1'b0;
    want(0);
    @(negedge clk_i);
    chk("t5_after_rst", 64'(m_addr), 64'h408);
    step();
    en[0] = 1'b0; want(1);
    step();
    en = '0;
    step();
    step();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/byte_arbiter.md
BYTE_ARBITER -- requirements
Module: byte_arbiter

Interface
REQ-001 SHALL have parameter PORTS, default 4: number of initiator ports, 2..8.
REQ-002 SHALL have parameter DATA_BYTE, default 4: data width in bytes.
REQ-003 SHALL have parameter ADDR_SIZE, default 32: address width in bits.
REQ-004 SHALL use one clock and an asynchronous active-low reset: clk_i  in  1  clock; rst_i  in  1  asynchronous reset, active low.
REQ-005 SHALL have useEnable_i  in  [PORTS]x1  per-port request valid.
REQ-006 SHALL have useIsWrite_i  in  [PORTS]x1  per-port write flag.
REQ-007 SHALL have useWriteMask_i  in  [PORTS]xDATA_BYTE  per-port byte enables.
REQ-008 SHALL have useAddr_i  in  [PORTS]xADDR_SIZE  per-port byte address.
REQ-009 SHALL have useWriteData_i  in  [PORTS]xDATA_BYTE*8  per-port write data.
REQ-010 SHALL have useReadData_o  out  [PORTS]xDATA_BYTE*8  per-port read data.
REQ-011 SHALL have useHold_o  out  [PORTS]x1  per-port stall.
REQ-012 SHALL have memEnable_o, memIsWrite_o, memWriteMask_o, memAddr_o, memWriteData_o  out, widths as the use side, single memory port.
REQ-013 SHALL have memReadData_i  in  DATA_BYTE*8 and memHold_i  in  1, from the memory.

Function
REQ-014 SHALL treat a request as accepted in a cycle where the port is granted, its enable is 1 and memHold_i is 0.
REQ-015 SHALL take read data from memory one cycle after acceptance, and SHALL return it to the accepting port one cycle after acceptance, combinationally from memReadData_i.
REQ-016 SHALL grant by round-robin: the search starts at the index after the last accepted port (ptr+1 mod PORTS); the lowest such index with enable=1 wins.
REQ-017 SHALL lock the grant while the granted request is held: if the granted port has enable=1 and memHold_i=1, the same port SHALL be granted next cycle regardless of other requests.
REQ-018 SHALL drive all mem*_o signals combinationally from the granted port; with no request, memEnable_o=0 and the other mem outputs SHALL be 0.
REQ-019 SHALL set useHold_o[i] = useEnable_i[i] & (i not granted | memHold_i); a port without enable SHALL see hold 0.
REQ-020 SHALL drive useReadData_o[i] = memReadData_i only when the response register marks port i as responder, and 0 otherwise.
REQ-021 SHALL register respValid/respPort on each accepted read; accepted writes SHALL clear respValid.
REQ-022 SHALL update ptr only on acceptance; a single requester SHALL be granted back-to-back without idle cycles.
REQ-023 SHALL ignore the lock and re-arbitrate when a locked port drops enable, which is a protocol violation; no state corruption SHALL result.
REQ-024 SHALL give identical behaviour for PORTS=2; ptr wrap-around from PORTS-1 to 0 SHALL be exact.

Reset
REQ-025 SHALL on rst_i=0 asynchronously clear ptr to PORTS-1, so that port 0 has first priority, and SHALL clear the lock and respValid.
REQ-026 SHALL keep all outputs at 0 in reset except those that are combinational from inputs; no request in flight SHALL survive reset.
REQ-027 SHALL deassert reset synchronously to clk_i; in the first cycle after reset, arbitration SHALL start from port 0.

Structure
REQ-028 SHALL place the memory-port field types (mask, address and data vector widths) in the shared package byte_pkg, which ByteDemux and its wrappers also use.
REQ-029 SHALL contain one sub-module, rr_pick (request vector plus pointer in, one-hot grant plus index out, combinational).
REQ-030 SHALL be at most 3 registers wide in state: ptr, lock flag plus locked index, and respValid plus respPort.

Verification
REQ-031 Reset with all ports requesting reads: grant order 0,1,2,3,0 on consecutive cycles; each port receives memReadData_i one cycle after its grant.
REQ-032 Port 2 writes addr 0x10 with mask 4'b0011 and data 0xDEADBEEF while memHold_i=1 for 3 cycles: mem outputs stay on port 2 for 4 cycles; ports 0, 1 and 3 are held; ptr becomes 2 after acceptance.
REQ-033 Only port 1 issues 5 reads back-to-back: memEnable_o=1 for 5 cycles; useHold_o[1]=0 throughout; 5 read data returned in order.
REQ-034 Port 3 read accepted, then port 0 write in the next cycle: useReadData_o[3]=memReadData_i during the write cycle; useReadData_o[0]=0.
REQ-035 rst_i falls while port 1 is locked under memHold_i=1: the lock and respValid clear immediately; after release, port 0 wins first.
